// File: rtl/trap_pkg.sv
// Shared types and constants for M-mode trap sequencing: FSM states, interrupt cause codes,
// CSR bit positions/addresses and the trap payload bundle handed to the CSR unit.
package trap_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_TRAP,
    ST_REDIR,
    ST_MRET
  } trap_state_t;

  localparam logic [3:0] CODE_MEI = 4'd11;
  localparam logic [3:0] CODE_MSI = 4'd3;
  localparam logic [3:0] CODE_MTI = 4'd7;

  localparam int MSTATUS_MIE_BIT = 3;
  localparam int MIE_MEIE_BIT    = 11;
  localparam int MIE_MSIE_BIT    = 3;
  localparam int MIE_MTIE_BIT    = 7;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  localparam logic [1:0] MTVEC_VECTORED = 2'b01;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] cause;
    logic [31:0] tval;
  } trap_payload_t;

  function automatic logic [31:0] irq_cause(input logic [3:0] code);
    return {1'b1, 27'b0, code};
  endfunction

  function automatic logic [31:0] exc_cause(input logic [3:0] code);
    return {28'b0, code};
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational M-mode interrupt pending/enable qualification and priority MEI > MSI > MTI.
// Zero latency; no flow control (pure function of the interrupt lines and enables).
module irq_prio_enc
  import trap_pkg::*;
(
  input  logic       mstatus_mie,
  input  logic       irq_ext,
  input  logic       irq_sw,
  input  logic       irq_timer,
  input  logic       meie,
  input  logic       msie,
  input  logic       mtie,
  output logic       irq_vld,
  output logic [3:0] irq_code
);

  logic ext_act, sw_act, tmr_act;

  assign ext_act = irq_ext & meie;
  assign sw_act  = irq_sw & msie;
  assign tmr_act = irq_timer & mtie;

  always_comb begin
    irq_vld  = mstatus_mie & (ext_act | sw_act | tmr_act);
    irq_code = CODE_MTI;
    if (ext_act) begin
      irq_code = CODE_MEI;
    end else if (sw_act) begin
      irq_code = CODE_MSI;
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap entry / MRET sequencer: exception -> trap_taken +1 -> redirect +2; MRET pulse +1;
// interrupt commits after DRAIN_CYCLES of fetch stall. Inputs are ignored while TRAP/REDIR/MRET run.
module trap_ctrl
  import trap_pkg::*;
#(
  parameter int DRAIN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        exc_valid,
  input  logic [3:0]  exc_code,
  input  logic [31:0] exc_pc,
  input  logic [31:0] exc_tval,
  input  logic        mret_req,
  input  logic        irq_ext,
  input  logic        irq_sw,
  input  logic        irq_timer,
  input  logic        mstatus_mie,
  input  logic [31:0] mie_csr,
  input  logic [31:0] resume_pc,
  input  logic [31:0] mtvec_base,
  input  logic [1:0]  mtvec_mode,
  input  logic [31:0] mepc,
  output logic        stall_fetch,
  output logic        flush,
  output logic        trap_taken,
  output logic [31:0] trap_pc,
  output logic [31:0] trap_cause,
  output logic [31:0] trap_tval,
  output logic        mret_exec,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

  trap_state_t   state, state_nxt;
  logic [3:0]    cnt, cnt_nxt;
  trap_payload_t pay, pay_nxt;
  trap_payload_t exc_pay;
  logic [31:0]   redir_pc_nxt;
  logic [31:0]   vec_pc;
  logic          irq_vld;
  logic [3:0]    irq_code;
  logic          unused_bits;

  assign unused_bits = ^{mie_csr[31:12], mie_csr[10:8], mie_csr[6:4], mie_csr[2:0],
                         mtvec_base[1:0], mepc[1:0]};

  irq_prio_enc u_irq_prio_enc (
    .mstatus_mie (mstatus_mie),
    .irq_ext     (irq_ext),
    .irq_sw      (irq_sw),
    .irq_timer   (irq_timer),
    .meie        (mie_csr[MIE_MEIE_BIT]),
    .msie        (mie_csr[MIE_MSIE_BIT]),
    .mtie        (mie_csr[MIE_MTIE_BIT]),
    .irq_vld     (irq_vld),
    .irq_code    (irq_code)
  );

  assign exc_pay = '{pc: exc_pc, cause: exc_cause(exc_code), tval: exc_tval};

  // Only interrupts vector; exceptions always land on the base even in vectored mode.
  assign vec_pc = (mtvec_mode == MTVEC_VECTORED && pay.cause[31])
                ? {mtvec_base[31:2], 2'b00} + {26'b0, pay.cause[3:0], 2'b00}
                : {mtvec_base[31:2], 2'b00};

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    pay_nxt      = pay;
    redir_pc_nxt = redirect_pc;
    unique case (state)
      ST_IDLE: begin
        if (exc_valid) begin
          state_nxt = ST_TRAP;
          pay_nxt   = exc_pay;
        end else if (mret_req) begin
          state_nxt    = ST_MRET;
          redir_pc_nxt = {mepc[31:2], 2'b00};
        end else if (irq_vld) begin
          state_nxt = ST_DRAIN;
          cnt_nxt   = 4'd0;
        end
      end
      ST_DRAIN: begin
        cnt_nxt = cnt + 4'd1;
        if (exc_valid) begin
          state_nxt = ST_TRAP;
          pay_nxt   = exc_pay;
        end else if (!irq_vld) begin
          state_nxt = ST_IDLE;
        end else if (cnt == DRAIN_LAST) begin
          state_nxt = ST_TRAP;
          pay_nxt   = '{pc: resume_pc, cause: irq_cause(irq_code), tval: 32'h0};
        end
      end
      ST_TRAP: begin
        state_nxt    = ST_REDIR;
        redir_pc_nxt = vec_pc;
      end
      ST_REDIR: state_nxt = ST_IDLE;
      ST_MRET:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      cnt            <= 4'd0;
      pay            <= '0;
      stall_fetch    <= 1'b0;
      flush          <= 1'b0;
      trap_taken     <= 1'b0;
      mret_exec      <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= 32'h0;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      pay            <= pay_nxt;
      stall_fetch    <= (state_nxt == ST_DRAIN) || (state_nxt == ST_TRAP) || (state_nxt == ST_REDIR);
      flush          <= (state_nxt == ST_TRAP) || (state_nxt == ST_MRET);
      trap_taken     <= (state_nxt == ST_TRAP);
      mret_exec      <= (state_nxt == ST_MRET);
      redirect_valid <= (state_nxt == ST_REDIR) || (state_nxt == ST_MRET);
      redirect_pc    <= redir_pc_nxt;
    end
  end

  assign trap_pc    = pay.pc;
  assign trap_cause = pay.cause;
  assign trap_tval  = pay.tval;

endmodule
